key_debounce: RTL and testbench

//  Conditions one raw push-button pin (KEY_x) for the counter/register datapath.

---
 rtl/key_debounce.sv | 155 +++++++++++++++
 tb/tb_key_debounce.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-time filter FSM, level and press/release strobes.
// Optional auto-repeat of the press strobe while held is enabled by defining KEY_AUTOREPEAT_EN.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
  input  logic clk50_i,
  input  logic arst_i,
  input  logic key_i,
  output logic key_level_o,
  output logic key_press_o,
  output logic key_release_o
);

  // state        | meaning
  // IDLE         | released, waiting for a pressed sample
  // PRESS_WAIT   | counting consecutive pressed samples
  // PRESSED      | debounced pressed
  // RELEASE_WAIT | counting consecutive released samples, level still 1
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_e;

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             REL_LVL  = ACTIVE_LOW;

  logic [1:0]       sync_q, sync_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             s_pressed;
  logic             rpt_fire;

  assign sync_d    = {sync_q[0], key_i};
  assign s_pressed = sync_q[1] ^ ACTIVE_LOW;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s_pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s_pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s_pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s_pressed) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    level_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    press_d   = (level_d & ~level_q) | rpt_fire;
    release_d = ~level_d & level_q;
  end

  always_ff @(posedge clk50_i) begin
    if (arst_i) begin
      sync_q    <= {2{REL_LVL}};
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;

  // Counter only advances in PRESSED; a bounce into RELEASE_WAIT pauses it rather than restarting.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_fire    = 1'b0;
    if (!level_d) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end else if (state_q == PRESSED) begin
      if (rpt_cnt_q == (rpt_first_q ? DELAY_LAST : PERIOD_LAST)) begin
        rpt_fire    = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk50_i) begin
    if (arst_i) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign key_level_o   = level_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random bouncing input, checked every cycle
// against a run-length model of the debounce rule (follows KEY_AUTOREPEAT_EN if defined).
module tb_key_debounce;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam bit AL = 1'b1;

  logic clk50_i = 1'b0;
  logic arst_i  = 1'b1;
  logic key_i   = 1'b1;
  logic key_level_o, key_press_o, key_release_o;

  key_debounce #(
    .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(AL), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk50_i(clk50_i), .arst_i(arst_i), .key_i(key_i),
    .key_level_o(key_level_o), .key_press_o(key_press_o), .key_release_o(key_release_o)
  );

  always #10 clk50_i = ~clk50_i;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: synced sample pipe, current level, length of current run of opposite samples.
  bit m_p1, m_p2, m_level, m_press, m_rel, m_first;
  int m_run, m_el;
  int press_log[$];
  int rel_log[$];

  task automatic tick(input logic k, input logic r);
    bit s, prev_level, was_held;
    key_i  = k;
    arst_i = r;
    @(posedge clk50_i);
    cyc++;
    if (r) begin
      m_p1 = 0; m_p2 = 0; m_level = 0; m_run = 0;
      m_press = 0; m_rel = 0; m_el = 0; m_first = 1;
    end else begin
      s    = m_p2;
      m_p2 = m_p1;
      m_p1 = AL ? ~k : k;
      prev_level = m_level;
      was_held   = m_level && (m_run == 0);
      if (s != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = s;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      m_press = m_level & ~prev_level;
      m_rel   = ~m_level & prev_level;
`ifdef KEY_AUTOREPEAT_EN
      if (!m_level) begin
        m_el = 0; m_first = 1;
      end else if (was_held) begin
        m_el++;
        if (m_el == (m_first ? RD : RP)) begin
          m_press = 1; m_el = 0; m_first = 0;
        end
      end
`else
      if (was_held) m_el = 0;
`endif
    end
    #1;
    checks++;
    assert (key_level_o === m_level) else begin
      errors++; $error("FAIL level cyc=%0d got=%b exp=%b", cyc, key_level_o, m_level);
    end
    checks++;
    assert (key_press_o === m_press) else begin
      errors++; $error("FAIL press cyc=%0d got=%b exp=%b", cyc, key_press_o, m_press);
    end
    checks++;
    assert (key_release_o === m_rel) else begin
      errors++; $error("FAIL release cyc=%0d got=%b exp=%b", cyc, key_release_o, m_rel);
    end
    if (key_press_o === 1'b1) press_log.push_back(cyc);
    if (key_release_o === 1'b1) rel_log.push_back(cyc);
  endtask

  task automatic ticks(input logic k, input int n);
    for (int i = 0; i < n; i++) tick(k, 1'b0);
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int first_off(input int q[$], input int base);
    return (q.size() > 0) ? q[0] - base : -1;
  endfunction

  initial begin
    int s0;
    int exp6[$];
    int got;
    logic k;
    int run;

    // 1: key held pressed through reset
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    s0 = cyc; press_log.delete();
    ticks(1'b0, 8);
    check_int("rst_press_n", press_log.size(), 1);
    check_int("rst_press_cyc", first_off(press_log, s0), 6);
    ticks(1'b1, 12);

    // 2 and 4: clean press then clean release
    s0 = cyc; press_log.delete(); rel_log.delete();
    ticks(1'b0, 8);
    check_int("press_n", press_log.size(), 1);
    check_int("press_cyc", first_off(press_log, s0), 6);
    s0 = cyc;
    ticks(1'b1, 8);
    check_int("release_n", rel_log.size(), 1);
    check_int("release_cyc", first_off(rel_log, s0), 6);

    // 3: toggling every 2 cycles never qualifies
    press_log.delete(); rel_log.delete();
    for (int i = 0; i < 20; i++) tick(((i / 2) % 2) ? 1'b1 : 1'b0, 1'b0);
    ticks(1'b1, 10);
    check_int("bounce_press_n", press_log.size(), 0);
    check_int("bounce_rel_n", rel_log.size(), 0);

    // 5: short release glitch while pressed
    ticks(1'b0, 8);
    rel_log.delete();
    ticks(1'b1, 3);
    ticks(1'b0, 10);
    check_int("glitch_rel_n", rel_log.size(), 0);
    ticks(1'b1, 12);

    // 6: long hold
`ifdef KEY_AUTOREPEAT_EN
    exp6 = '{6, 16, 19, 22, 25, 28};
`else
    exp6 = '{6};
`endif
    s0 = cyc; press_log.delete();
    ticks(1'b0, 30);
    check_int("hold_press_n", press_log.size(), exp6.size());
    for (int i = 0; i < exp6.size(); i++) begin
      got = (i < press_log.size()) ? press_log[i] - s0 : -1;
      check_int("hold_press_cyc", got, exp6[i]);
    end
    ticks(1'b1, 12);

    // reset in the middle of PRESS_WAIT drops the pending press
    press_log.delete();
    ticks(1'b0, 4);
    tick(1'b0, 1'b1);
    ticks(1'b1, 12);
    check_int("rst_midwait_n", press_log.size(), 0);

    // random bouncing runs with occasional reset
    k = 1'b1;
    for (int i = 0; i < 400; i++) begin
      run = int'($urandom_range(1, 8));
      k = ~k;
      for (int j = 0; j < run; j++) tick(k, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
